// File: rtl/video_out_hmag.sv
// Horizontal magnifier: captures VDP scan lines into a ping-pong line buffer
// and replays the previous line stretched by a DDA scaler with linear
// interpolation between neighbouring source pixels. Output is 8-bit RGB,
// three clocks behind the output horizontal counter.
module video_out_hmag #(
  parameter int SRC_WIDTH   = 576,
  parameter int OUT_X_START = 16,
  parameter int DDA_STEP    = 128
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [10:0] vdp_hcounter,
  input  logic [1:0]  vdp_vcounter,
  input  logic [10:0] h_cnt,
  input  logic [5:0]  vdp_r,
  input  logic [5:0]  vdp_g,
  input  logic [5:0]  vdp_b,
  output logic [7:0]  video_r,
  output logic [7:0]  video_g,
  output logic [7:0]  video_b,
  input  logic [7:0]  reg_left_offset,
  input  logic [7:0]  reg_denominator,
  input  logic [5:0]  reg_normalize
);

  localparam logic [9:0] LAST_SRC = 10'(SRC_WIDTH - 1);

  // Interpolation weight: (rem * norm) >> 7, clamped to 0..63.
  function automatic logic [5:0] sat_weight(input logic [7:0] r, input logic [5:0] n);
    logic [6:0] q;
    q = 7'((14'(r) * 14'(n)) >> 7);
    return (q > 7'd63) ? 6'd63 : q[5:0];
  endfunction

  // 6-bit pixel times 7-bit weight; the largest product (63*64) fits 12 bits.
  function automatic logic [11:0] mul_px(input logic [5:0] a, input logic [6:0] b);
    return 12'(a) * 12'(b);
  endfunction

  // Sum of the two weighted terms scaled back to 8 bits.
  function automatic logic [7:0] blend(input logic [11:0] lo, input logic [11:0] hi);
    return 8'((13'(lo) + 13'(hi)) >> 4);
  endfunction

  // ---------------------------------------------------------------------------
  // Line buffer: two banks, duplicated so two pixels can be read per clock.
  // ---------------------------------------------------------------------------
  logic [17:0] ram_a [0:1][0:SRC_WIDTH-1];
  logic [17:0] ram_b [0:1][0:SRC_WIDTH-1];

  logic        wr_en;
  logic [9:0]  wr_addr;
  logic        wr_bank;
  logic        rd_bank;
  logic [17:0] pix_in;
  logic        vcnt_unused;

  assign wr_en       = enable && (vdp_hcounter < 11'(2 * SRC_WIDTH));
  assign wr_addr     = vdp_hcounter[10:1];
  assign wr_bank     = vdp_vcounter[0];
  assign rd_bank     = ~vdp_vcounter[0];
  assign pix_in      = {vdp_r, vdp_g, vdp_b};
  assign vcnt_unused = vdp_vcounter[1];

  // Capture the incoming VDP line into both copies of the write bank.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram_a[wr_bank][wr_addr] <= pix_in;
      ram_b[wr_bank][wr_addr] <= pix_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Window control and DDA
  // ---------------------------------------------------------------------------
  logic        active;
  logic [7:0]  rem;
  logic [9:0]  src;
  logic [7:0]  den_lat;
  logic [5:0]  norm_lat;
  logic [10:0] win_pre;
  logic        start_hit;
  logic [8:0]  rem_sum;
  logic [8:0]  rem_dif;
  logic        carry;
  logic [9:0]  src_nx;

  assign win_pre   = 11'(OUT_X_START) + {3'b000, reg_left_offset} - 11'd1;
  assign start_hit = (h_cnt == win_pre);
  assign rem_sum   = {1'b0, rem} + 9'(DDA_STEP);
  assign rem_dif   = rem_sum - {1'b0, den_lat};
  assign carry     = (rem_sum >= {1'b0, den_lat});
  assign src_nx    = (src == LAST_SRC) ? src : src + 10'd1;

  // Window start loads the scaler and latches the ratio registers; the DDA
  // then steps once per clock until the last source pixel is consumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active   <= 1'b0;
      rem      <= '0;
      src      <= '0;
      den_lat  <= '0;
      norm_lat <= '0;
    end else if (start_hit) begin
      active   <= 1'b1;
      rem      <= '0;
      src      <= '0;
      den_lat  <= reg_denominator;
      norm_lat <= reg_normalize;
    end else if (h_cnt == 11'd0) begin
      active <= 1'b0;
    end else if (active) begin
      if (carry) begin
        rem <= rem_dif[7:0];
        if (src == LAST_SRC) begin
          active <= 1'b0;
        end else begin
          src <= src + 10'd1;
        end
      end else begin
        rem <= rem_sum[7:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p0: line buffer read and weight
  // ---------------------------------------------------------------------------
  logic [17:0] pix0_p0;
  logic [17:0] pix1_p0;
  logic [5:0]  w_p0;
  logic        vld_p0;

  // Fetch the current and next source pixel and derive the blend weight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix0_p0 <= '0;
      pix1_p0 <= '0;
      w_p0    <= '0;
      vld_p0  <= 1'b0;
    end else begin
      pix0_p0 <= ram_a[rd_bank][src];
      pix1_p0 <= ram_b[rd_bank][src_nx];
      w_p0    <= sat_weight(rem, norm_lat);
      vld_p0  <= active;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: weighted products
  // ---------------------------------------------------------------------------
  logic [11:0] lo_r_p1, hi_r_p1;
  logic [11:0] lo_g_p1, hi_g_p1;
  logic [11:0] lo_b_p1, hi_b_p1;
  logic        vld_p1;
  logic [6:0]  wa_p0;
  logic [6:0]  wb_p0;

  assign wb_p0 = {1'b0, w_p0};
  assign wa_p0 = 7'd64 - wb_p0;

  // Multiply each channel of both neighbours by its weight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lo_r_p1 <= '0;
      hi_r_p1 <= '0;
      lo_g_p1 <= '0;
      hi_g_p1 <= '0;
      lo_b_p1 <= '0;
      hi_b_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      lo_r_p1 <= mul_px(pix0_p0[17:12], wa_p0);
      hi_r_p1 <= mul_px(pix1_p0[17:12], wb_p0);
      lo_g_p1 <= mul_px(pix0_p0[11:6], wa_p0);
      hi_g_p1 <= mul_px(pix1_p0[11:6], wb_p0);
      lo_b_p1 <= mul_px(pix0_p0[5:0], wa_p0);
      hi_b_p1 <= mul_px(pix1_p0[5:0], wb_p0);
      vld_p1  <= vld_p0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p2: sum, scale and blank outside the window
  // ---------------------------------------------------------------------------
  // Register the blended pixel, or black when outside the active window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      video_r <= '0;
      video_g <= '0;
      video_b <= '0;
    end else if (vld_p1) begin
      video_r <= blend(lo_r_p1, hi_r_p1);
      video_g <= blend(lo_g_p1, hi_g_p1);
      video_b <= blend(lo_b_p1, hi_b_p1);
    end else begin
      video_r <= '0;
      video_g <= '0;
      video_b <= '0;
    end
  end

endmodule

// File: tb/tb_video_out_hmag.sv
// Bench for video_out_hmag: drives full scan lines with a shared horizontal
// counter and compares every output pixel against a closed-form model of the
// magnifier, plus table vectors and hand sequences for reset, offset and banks.
module tb_video_out_hmag;

  localparam int SRCW    = 576;
  localparam int XSTART  = 16;
  localparam int STEP    = 128;
  localparam int LINELEN = 1368;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [10:0] vdp_hcounter;
  logic [1:0]  vdp_vcounter;
  logic [10:0] h_cnt;
  logic [5:0]  vdp_r, vdp_g, vdp_b;
  logic [7:0]  video_r, video_g, video_b;
  logic [7:0]  reg_left_offset;
  logic [7:0]  reg_denominator;
  logic [5:0]  reg_normalize;

  video_out_hmag dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .vdp_hcounter    (vdp_hcounter),
    .vdp_vcounter    (vdp_vcounter),
    .h_cnt           (h_cnt),
    .vdp_r           (vdp_r),
    .vdp_g           (vdp_g),
    .vdp_b           (vdp_b),
    .video_r         (video_r),
    .video_g         (video_g),
    .video_b         (video_b),
    .reg_left_offset (reg_left_offset),
    .reg_denominator (reg_denominator),
    .reg_normalize   (reg_normalize)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int line_no = 0;
  bit prev_ok = 0;
  int den_m, norm_m, off_m;
  logic [17:0] pix_cur  [0:SRCW-1];
  logic [17:0] pix_prev [0:SRCW-1];

  typedef struct {
    int          den;
    int          norm;
    int          off;
    logic [17:0] pix;
    logic [23:0] exp_px;
    int          exp_first;
  } vec_t;

  vec_t tbl [4];

  task automatic check(input string nm, input int h, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s line=%0d h=%0d got=%0h want=%0h", nm, line_no, h, got, want);
    end
  endtask

  // Closed-form expectation: window pixel k sits at source position k*STEP/den.
  function automatic logic [23:0] model_out(input int h, output bit inwin);
    int k, s, s1, rem, w;
    logic [23:0] o;
    inwin = 0;
    o = '0;
    k = h - 3 - (XSTART + off_m);
    if (k >= 0) begin
      s = (k * STEP) / den_m;
      if (s < SRCW) begin
        inwin = 1;
        rem = k * STEP - s * den_m;
        w = (rem * norm_m) / 128;
        if (w > 63) w = 63;
        s1 = (s < SRCW - 1) ? s + 1 : SRCW - 1;
        for (int c = 0; c < 3; c++) begin
          int a, b, v;
          a = int'(pix_prev[s][17-6*c -: 6]);
          b = int'(pix_prev[s1][17-6*c -: 6]);
          v = (a * (64 - w) + b * w) / 16;
          o[23-8*c -: 8] = 8'(v);
        end
      end
    end
    return o;
  endfunction

  task automatic apply_regs(input int d, input int n, input int o);
    den_m = d;
    norm_m = n;
    off_m = o;
    reg_denominator = 8'(d);
    reg_normalize   = 6'(n);
    reg_left_offset = 8'(o);
  endtask

  // mode 0: flat colour, 1: red ramp i mod 64, 2: random
  task automatic set_line(input int mode, input logic [17:0] v);
    for (int i = 0; i < SRCW; i++) begin
      case (mode)
        0:       pix_cur[i] = v;
        1:       pix_cur[i] = {6'(i % 64), 12'd0};
        default: pix_cur[i] = 18'($urandom);
      endcase
    end
  endtask

  task automatic run_line(input int rst_at, input int probe_h,
                          output logic [23:0] probe_val, output int first_nz);
    bit kill;
    bit inwin;
    logic [23:0] got, want;
    kill = 0;
    first_nz = -1;
    probe_val = '0;
    vdp_vcounter = 2'(line_no);
    for (int h = 0; h < LINELEN; h++) begin
      @(negedge clk);
      h_cnt        = 11'(h);
      vdp_hcounter = 11'(h);
      enable       = (h % 2 == 1);
      if (h < 2 * SRCW) {vdp_r, vdp_g, vdp_b} = pix_cur[h / 2];
      if (h == rst_at) begin
        reset_n = 1'b0;
        kill = 1;
        #1;
        check("async_rst", h, 32'({video_r, video_g, video_b}), 32'd0);
      end
      if (h == rst_at + 3) reset_n = 1'b1;
      got  = {video_r, video_g, video_b};
      want = model_out(h, inwin);
      if (kill) want = '0;
      if (kill || !inwin || prev_ok) check("pix", h, 32'(got), 32'(want));
      if (got != '0 && first_nz < 0) first_nz = h;
      if (h == probe_h) probe_val = got;
    end
    for (int i = 0; i < SRCW; i++) pix_prev[i] = pix_cur[i];
    prev_ok = 1;
    line_no++;
  endtask

  initial begin
    #4ms;
    $display("FAIL watchdog line=%0d", line_no);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] pv;
    int fnz;
    int par;

    tbl[0] = '{den: 200, norm: 40, off: 0,   pix: {6'd1,  6'd0,  6'd0},  exp_px: 24'h040000, exp_first: 19};
    tbl[1] = '{den: 144, norm: 56, off: 0,   pix: {6'd63, 6'd63, 6'd63}, exp_px: 24'hFCFCFC, exp_first: 19};
    tbl[2] = '{den: 160, norm: 51, off: 50,  pix: {6'd10, 6'd20, 6'd30}, exp_px: 24'h285078, exp_first: 69};
    tbl[3] = '{den: 176, norm: 46, off: 112, pix: {6'd0,  6'd33, 6'd5},  exp_px: 24'h008414, exp_first: 131};

    reset_n = 1'b0;
    enable = 1'b0;
    vdp_hcounter = '0;
    vdp_vcounter = '0;
    h_cnt = '0;
    {vdp_r, vdp_g, vdp_b} = '0;
    apply_regs(200, 40, 0);
    #1;
    check("reset_state", -1, 32'({video_r, video_g, video_b}), 32'd0);
    repeat (3) @(negedge clk);
    check("reset_hold", -1, 32'({video_r, video_g, video_b}), 32'd0);
    reset_n = 1'b1;

    // First line reads an unwritten bank: only the blanked region is checked.
    set_line(0, {6'd1, 6'd0, 6'd0});
    run_line(-10, -1, pv, fnz);

    for (int t = 0; t < 4; t++) begin
      apply_regs(tbl[t].den, tbl[t].norm, tbl[t].off);
      set_line(0, tbl[t].pix);
      run_line(-10, -1, pv, fnz);
      run_line(-10, XSTART + tbl[t].off + 3 + 100, pv, fnz);
      check("tbl_probe", t, 32'(pv), 32'(tbl[t].exp_px));
      check("tbl_first", t, 32'(fnz), 32'(tbl[t].exp_first));
    end

    // Ramp: at k=25 the remainder is zero and src=16, so red is 4*16.
    apply_regs(200, 40, 0);
    set_line(1, '0);
    run_line(-10, -1, pv, fnz);
    run_line(-10, XSTART + 3 + 25, pv, fnz);
    check("ramp_rem0", 25, 32'(pv), 32'(24'h400000));

    // Bank alternation: each line shows the previous line's colour.
    for (int j = 0; j < 4; j++) begin
      par = line_no % 2;
      set_line(0, {(par == 0) ? 6'd10 : 6'd20, 12'd0});
      run_line(-10, XSTART + 3 + 300, pv, fnz);
      if (j > 0) check("bank", j, 32'(pv), (par == 0) ? 32'h500000 : 32'h280000);
    end

    // Mid-line reset: output drops at once and stays black until next window.
    apply_regs(150, 54, 30);
    set_line(2, '0);
    run_line(-10, -1, pv, fnz);
    set_line(2, '0);
    run_line(XSTART + 30 + 203, -1, pv, fnz);
    set_line(2, '0);
    run_line(-10, -1, pv, fnz);

    // Random lines and random ratio/offset settings.
    for (int j = 0; j < 6; j++) begin
      int d;
      d = int'($urandom_range(144, 200));
      apply_regs(d, 8192 / d, int'($urandom_range(0, 112)));
      set_line(2, '0);
      run_line(-10, -1, pv, fnz);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
